// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the PISO serializer slice.
// Holds the FSM state encoding and the counter width helper.
package pca_mem_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word handshake into the PISO serializer.
// master drives the word, slave (the serializer) returns ready.
interface piso_serializer_if
  import pca_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit index counter for the serializer: gated increment, clear,
// terminal (DATA_W-1) and pre-terminal (DATA_W-2) flags.
module piso_bit_counter
  import pca_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic pre_tc
);

  localparam int CW = cnt_w(DATA_W);

  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (en && !tc) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign tc     = (bit_cnt == CW'(DATA_W - 1));
  assign pre_tc = (bit_cnt == CW'(DATA_W - 2));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter feeding the serial buffer chain.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import pca_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  piso_serializer_if.slave in_if,
  input  logic ser_en,
  output logic ser_out,
  output logic ser_valid,
  output logic ser_last,
  output logic busy
);

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e state, state_d;

  logic [DATA_W-1:0] sreg, sreg_d;
  logic [DATA_W-1:0] ld_rest, sh_rest;
  logic ld_bit, sh_bit;
  logic out_d, valid_d, last_d;
  logic cnt_en, cnt_clr;
  logic tc, pre_tc;
  logic load;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  piso_bit_counter #(
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .tc     (tc),
    .pre_tc (pre_tc)
  );

`ifdef PISO_PARITY_EN
  assign in_if.in_ready = (state == IDLE) ||
                          (state == PARITY && ser_en);
`else
  assign in_if.in_ready = (state == IDLE) ||
                          (state == SHIFT && tc && ser_en);
`endif

  assign load = in_if.in_valid && in_if.in_ready;
  assign busy = (state != IDLE);

  always_comb begin
    ld_bit  = in_if.in_data[0];
    ld_rest = in_if.in_data >> 1;
    sh_bit  = sreg[0];
    sh_rest = sreg >> 1;
    if (MSB_FIRST) begin
      ld_bit  = in_if.in_data[DATA_W-1];
      ld_rest = in_if.in_data << 1;
      sh_bit  = sreg[DATA_W-1];
      sh_rest = sreg << 1;
    end
  end

  always_comb begin
    state_d = state;
    out_d   = ser_out;
    valid_d = ser_valid;
    last_d  = ser_last;
    sreg_d  = sreg;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state)
      IDLE: begin
      end
      SHIFT: begin
        if (ser_en && !tc) begin
          out_d  = sh_bit;
          sreg_d = sh_rest;
          cnt_en = 1'b1;
          last_d = pre_tc && !PAR_EN;
        end else if (ser_en) begin
          cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
          out_d   = par_q;
          last_d  = 1'b1;
`else
          state_d = IDLE;
          out_d   = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (ser_en) begin
          state_d = IDLE;
          out_d   = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // A load only happens at frame end or idle, so it overrides the above.
    if (load) begin
      state_d = SHIFT;
      out_d   = ld_bit;
      valid_d = 1'b1;
      last_d  = 1'b0;
      sreg_d  = ld_rest;
      cnt_en  = 1'b0;
      cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
      par_d   = ^in_if.in_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      ser_out   <= out_d;
      ser_valid <= valid_d;
      ser_last  <= last_d;
`ifdef PISO_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: 32-bit LSB-first and 8-bit MSB-first
// instances checked against a frame-level reference model.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FW32 = 32 + PAR;
  localparam int FW8  = 8 + PAR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic en32, so32, sv32, sl32, bz32;
  logic en8, so8, sv8, sl8, bz8;

  piso_serializer_if #(.DATA_W(32)) b32 ();
  piso_serializer_if #(.DATA_W(8))  b8 ();

  piso_serializer #(
    .DATA_W    (32),
    .MSB_FIRST (1'b0)
  ) u32 (
    .clk       (clk),
    .rst       (rst),
    .in_if     (b32.slave),
    .ser_en    (en32),
    .ser_out   (so32),
    .ser_valid (sv32),
    .ser_last  (sl32),
    .busy      (bz32)
  );

  piso_serializer #(
    .DATA_W    (8),
    .MSB_FIRST (1'b1)
  ) u8 (
    .clk       (clk),
    .rst       (rst),
    .in_if     (b8.slave),
    .ser_en    (en8),
    .ser_out   (so8),
    .ser_valid (sv8),
    .ser_last  (sl8),
    .busy      (bz8)
  );

  // Reference model: current frame bits and position in it (-1 = idle).
  logic [63:0] frm32;
  int          pos32 = -1;
  int          acc32 = 0;
  logic        rdy_exp32;
  logic        rdy_obs32;

  function automatic logic [63:0] mk_frame(
    input logic [31:0] w, input int dw, input bit msb);
    logic [63:0] f;
    logic p;
    f = '0;
    p = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f[i] = msb ? w[dw-1-i] : w[i];
      p = p ^ w[i];
    end
    if (PAR == 1) f[dw] = p;
    return f;
  endfunction

  function automatic logic [3:0] exp_out32();
    if (pos32 < 0) return 4'b0000;
    return {1'b1, frm32[pos32], pos32 == FW32 - 1, 1'b1};
  endfunction

  task automatic step32(input logic [31:0] d, input logic v,
                        input logic en);
    b32.in_data  = d;
    b32.in_valid = v;
    en32         = en;
    #1;
    rdy_exp32 = (pos32 < 0) || (pos32 == FW32 - 1 && en);
    rdy_obs32 = b32.in_ready;
    @(posedge clk);
    if (v && rdy_exp32) begin
      frm32 = mk_frame(d, 32, 1'b0);
      pos32 = 0;
      acc32++;
    end else if (pos32 >= 0 && en) begin
      pos32 = (pos32 == FW32 - 1) ? -1 : pos32 + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({sv32, so32, sl32, bz32, b32.in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset32 got %b want 00001",
               {sv32, so32, sl32, bz32, b32.in_ready});
    end
    vectors++;
    if ({sv8, so8, sl8, bz8, b8.in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset8 got %b want 00001",
               {sv8, so8, sl8, bz8, b8.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [31:0] w, input string nm);
    for (int i = 0; i < FW32 + 3; i++) begin
      step32((i == 0) ? w : 32'($urandom), i == 0, 1'b1);
      vectors++;
      if (rdy_obs32 !== rdy_exp32) begin
        errors++;
        $display("FAIL %s rdy cyc%0d got %b want %b",
                 nm, i, rdy_obs32, rdy_exp32);
      end
      vectors++;
      if ({sv32, so32, sl32, bz32} !== exp_out32()) begin
        errors++;
        $display("FAIL %s out cyc%0d got %b want %b",
                 nm, i, {sv32, so32, sl32, bz32}, exp_out32());
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcnt;
    acc32 = 0;
    vcnt  = 0;
    for (int i = 0; i < 2 * FW32 + 3; i++) begin
      step32((acc32 == 0) ? 32'hA5A5_A5A5 : 32'hFFFF_0000,
             acc32 < 2, 1'b1);
      if (sv32) vcnt++;
      vectors++;
      if (rdy_obs32 !== rdy_exp32) begin
        errors++;
        $display("FAIL b2b rdy cyc%0d got %b want %b",
                 i, rdy_obs32, rdy_exp32);
      end
      vectors++;
      if ({sv32, so32, sl32, bz32} !== exp_out32()) begin
        errors++;
        $display("FAIL b2b out cyc%0d got %b want %b",
                 i, {sv32, so32, sl32, bz32}, exp_out32());
      end
    end
    vectors++;
    if (vcnt !== 2 * FW32) begin
      errors++;
      $display("FAIL b2b valid_cycles got %0d want %0d", vcnt, 2 * FW32);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16 + FW32 + 2; i++) begin
      if (i == 0)
        step32(32'h1234_5678, 1'b1, 1'b1);
      else if (i > 10 && i <= 15)
        step32(32'($urandom), 1'b1, 1'b0);
      else
        step32(32'($urandom), 1'b0, 1'b1);
      vectors++;
      if (rdy_obs32 !== rdy_exp32) begin
        errors++;
        $display("FAIL stall rdy cyc%0d got %b want %b",
                 i, rdy_obs32, rdy_exp32);
      end
      vectors++;
      if ({sv32, so32, sl32, bz32} !== exp_out32()) begin
        errors++;
        $display("FAIL stall out cyc%0d got %b want %b",
                 i, {sv32, so32, sl32, bz32}, exp_out32());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 18; i++) begin
      step32((i == 0) ? 32'hFFFF_FFFF : 32'h0, i == 0, 1'b1);
      vectors++;
      if ({sv32, so32, sl32, bz32} !== exp_out32()) begin
        errors++;
        $display("FAIL arst pre cyc%0d got %b want %b",
                 i, {sv32, so32, sl32, bz32}, exp_out32());
      end
    end
    #1 rst = 1'b1;
    #1;
    pos32 = -1;
    vectors++;
    if ({sv32, so32, sl32, bz32, b32.in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL arst now got %b want 00001",
               {sv32, so32, sl32, bz32, b32.in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    test_single(32'h0F0F_0F0F, "arst_next");
  endtask

  task automatic test_msb8();
    logic [63:0] f;
    f = mk_frame(32'h80, 8, 1'b1);
    b8.in_data  = 8'h80;
    b8.in_valid = 1'b1;
    en8         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.in_data  = 8'h7F;
    for (int i = 0; i < FW8; i++) begin
      vectors++;
      if ({sv8, so8, sl8} !== {1'b1, f[i], i == FW8 - 1}) begin
        errors++;
        $display("FAIL msb8 bit%0d got %b want %b",
                 i, {sv8, so8, sl8}, {1'b1, f[i], i == FW8 - 1});
      end
      @(negedge clk);
    end
    vectors++;
    if ({sv8, so8, sl8, bz8, b8.in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL msb8 idle got %b want 00001",
               {sv8, so8, sl8, bz8, b8.in_ready});
    end
  endtask

  task automatic test_parity(input logic [31:0] w, input logic p);
    step32(w, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) step32(32'h0, 1'b0, 1'b1);
    vectors++;
    if ({sv32, so32, sl32} !== {1'b1, p, 1'b1}) begin
      errors++;
      $display("FAIL parity %h got %b want %b",
               w, {sv32, so32, sl32}, {1'b1, p, 1'b1});
    end
    step32(32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step32(32'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0);
      vectors++;
      if (rdy_obs32 !== rdy_exp32) begin
        errors++;
        $display("FAIL rand rdy cyc%0d got %b want %b",
                 i, rdy_obs32, rdy_exp32);
      end
      vectors++;
      if ({sv32, so32, sl32, bz32} !== exp_out32()) begin
        errors++;
        $display("FAIL rand out cyc%0d got %b want %b",
                 i, {sv32, so32, sl32, bz32}, exp_out32());
      end
    end
  endtask

  initial begin
    b32.in_data  = '0;
    b32.in_valid = 1'b0;
    en32         = 1'b0;
    b8.in_data   = '0;
    b8.in_valid  = 1'b0;
    en8          = 1'b0;
    test_reset();
    test_single(32'h0000_0001, "single");
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_msb8();
`ifdef PISO_PARITY_EN
    test_parity(32'h0000_0007, 1'b1);
    test_parity(32'h0000_0003, 1'b0);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter for the memory unit's 1-bit serial buffer path. It accepts DATA_W-bit words over a valid/ready handshake and drives them one bit per enabled clock onto the serial line that feeds the SISO shift-register chain. It supports back-to-back words with no idle gap and holds under downstream stall via ser_en.

Parameters:
DATA_W, 32, word width in bits (minimum 2)
MSB_FIRST, 0, 0 = LSB transmitted first (matches the shift-register fill order); 1 = MSB transmitted first

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_W  parallel word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle (combinational)
ser_en  input  1  downstream advance enable; 0 = stall, hold all serial outputs
ser_out  output  1  serial data bit (registered)
ser_valid  output  1  ser_out carries a valid bit (registered)
ser_last  output  1  current bit is the final bit of the frame (registered)
busy  output  1  FSM not in IDLE (registered state decode)

Behaviour:
- Reset (async, any time, including mid-word): state=IDLE; ser_out=0, ser_valid=0, ser_last=0, busy=0, bit_cnt=0, shift reg=0. The partial word is discarded, with no resume.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- Bit counter: bit_cnt is 0..DATA_W-1 and is the index of the bit currently on ser_out.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==SHIFT && bit_cnt==DATA_W-1 && ser_en).
  - Without parity, in_ready is never high while stalled.
- Accept in IDLE:
  - Next edge: state to SHIFT; the first bit (in_data[0], or in_data[DATA_W-1] when MSB_FIRST) goes to ser_out.
  - ser_valid=1, bit_cnt=0, the remaining bits are loaded into the shift reg.
  - Latency is 1 clock from the accept edge to the first valid bit.
- SHIFT with ser_en=1 and bit_cnt<DATA_W-1: the next bit goes to ser_out and bit_cnt increments.
  - ser_last becomes 1 on the edge where bit_cnt becomes DATA_W-1.
- SHIFT with ser_en=0: ser_out, ser_valid, ser_last, bit_cnt and the shift reg hold. in_data is ignored.
- Last bit shown, ser_en=1:
  - If in_valid=1: load the new word exactly as from IDLE. There is no gap, so ser_valid stays 1 and ser_last returns to 0.
  - Otherwise: state to IDLE, and ser_valid, ser_last and ser_out go to 0.
- IDLE: ser_en has no effect. in_data is sampled only at the accept edge and may change afterwards.
- Throughput: 1 word per DATA_W enabled cycles.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - After bit DATA_W-1 with ser_en=1, the FSM enters PARITY and ser_out = XOR of the whole word (even parity).
  - ser_last is 0 on data bit DATA_W-1 and 1 on the parity bit.
  - in_ready is high in PARITY when ser_en=1 instead of on the last data bit.
  - The frame is DATA_W+1 bits.
- Undefined: no PARITY state and no parity logic; the frame is DATA_W bits.

Decomposition:
- Package pca_mem_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - DATA_W default constant (32)
  - bit-count width = clog2(DATA_W) helper
- One natural sub-module, piso_bit_counter:
  - enable-gated up-counter with load-to-zero and terminal-count flag
  - terminal-count flag drives ser_last and in_ready
- Parity accumulation stays inline, XOR-reduced at load.

Test Plan:
- Reset then single word 0x0000_0001, LSB-first, ser_en=1: ser_valid=1 for 32 cycles starting 1 clk after accept. ser_out=1 on bit 0 only, ser_last only on the 32nd bit, then IDLE with in_ready=1.
- Back-to-back 0xA5A5_A5A5 then 0xFFFF_0000 with in_valid held: the second accept happens while the first word's last bit is shown. No ser_valid gap; 64 consecutive correct bits.
- Stall: ser_en=0 for 5 cycles at bit 10 of 0x1234_5678. ser_out/bit index hold, in_ready=0, and the transfer resumes with bit 11 intact.
- Async rst pulse at bit 17: all outputs are 0 immediately without a clock edge. The next word 0x0F0F_0F0F serializes from bit 0.
- MSB_FIRST=1, DATA_W=8, word 0x80: the first serial bit is 1 and the next 7 are 0, with ser_last on the 8th.
- PISO_PARITY_EN defined, word 0x0000_0007: the 33rd bit is 1 with ser_last=1. For word 0x0000_0003 the 33rd bit is 0.
